// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store.
// Defining ARB_PERF_EN adds saturating conflict/stall counters; otherwise those ports read 0.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifReq,
    input  logic [AW-1:0] ifAddr,
    input  logic          ifKill,
    output logic [DW-1:0] ifRdata,
    output logic          ifReady,
    output logic          ifStall,
    input  logic          dReq,
    input  logic          dWe,
    input  logic [AW-1:0] dAddr,
    input  logic [DW-1:0] dWdata,
    output logic [DW-1:0] dRdata,
    output logic          dReady,
    output logic          dStall,
    output logic [AW-1:0] mAddr,
    output logic [DW-1:0] mWdata,
    output logic          mRead,
    output logic          mWrite,
    input  logic [DW-1:0] mRdata,
    input  logic          mReady,
    output logic          timeoutErr,
    output logic [31:0]   conflictCnt,
    output logic [31:0]   stallCnt
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state, w_next;
    logic          r_owner_d, r_we, r_killed, r_timeout;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_if_rdata, r_d_rdata;
    logic          w_grant_d, w_grant_if, w_expire;

    always_comb begin
        w_next     = r_state;
        w_grant_d  = 1'b0;
        w_grant_if = 1'b0;
        w_expire   = 1'b0;
        case (r_state)
            IDLE: begin
                // data wins a tie: it belongs to the older instruction
                w_grant_d  = dReq;
                w_grant_if = ~dReq & ifReq & ~ifKill;
                w_next     = (w_grant_d | w_grant_if) ? WAIT : IDLE;
            end
            WAIT: begin
                w_expire = ~mReady & (r_cnt == LAST);
                w_next   = (mReady | w_expire) ? RESP : WAIT;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner_d  <= 1'b0;
            r_we       <= 1'b0;
            r_killed   <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_expire;
            if (w_grant_d | w_grant_if) begin
                r_owner_d <= w_grant_d;
                r_we      <= w_grant_d & dWe;
                r_addr    <= w_grant_d ? dAddr : ifAddr;
                r_cnt     <= '0;
            end
            if (w_grant_d)
                r_wdata <= dWdata;
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
                // a flushed fetch still finishes on the memory side
                if (~r_owner_d & ifKill)
                    r_killed <= 1'b1;
                if (mReady | w_expire) begin
                    if (r_owner_d)
                        r_d_rdata <= mReady ? mRdata : '0;
                    else
                        r_if_rdata <= mReady ? mRdata : '0;
                end
            end
            if (r_state == RESP)
                r_killed <= 1'b0;
        end
    end

    assign mAddr      = r_addr;
    assign mWdata     = r_wdata;
    assign mRead      = (r_state == WAIT) & ~r_we;
    assign mWrite     = (r_state == WAIT) & r_we;
    assign ifRdata    = r_if_rdata;
    assign dRdata     = r_d_rdata;
    assign ifReady    = (r_state == RESP) & ~r_owner_d & ~(r_killed | ifKill);
    assign dReady     = (r_state == RESP) & r_owner_d;
    assign ifStall    = ifReq & ~ifReady;
    assign dStall     = dReq & ~dReady;
    assign timeoutErr = r_timeout;

`ifdef ARB_PERF_EN
    logic [31:0] r_conflict, r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict <= '0;
            r_stall    <= '0;
        end else begin
            if ((r_state == IDLE) & ifReq & dReq & ~&r_conflict)
                r_conflict <= r_conflict + 32'd1;
            if ((ifStall | dStall) & ~&r_stall)
                r_stall <= r_stall + 32'd1;
        end
    end

    assign conflictCnt = r_conflict;
    assign stallCnt    = r_stall;
`else
    assign conflictCnt = '0;
    assign stallCnt    = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed literal scenarios, then random traffic checked every cycle
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, ifReq, ifKill, dReq, dWe, mReady;
    logic [31:0] ifAddr, dAddr, dWdata, mRdata;
    logic [31:0] ifRdata, dRdata, mAddr, mWdata, conflictCnt, stallCnt;
    logic        ifReady, ifStall, dReady, dStall, mRead, mWrite, timeoutErr;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifKill(ifKill), .ifRdata(ifRdata),
        .ifReady(ifReady), .ifStall(ifStall),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata),
        .dReady(dReady), .dStall(dStall),
        .mAddr(mAddr), .mWdata(mWdata), .mRead(mRead), .mWrite(mWrite),
        .mRdata(mRdata), .mReady(mReady), .timeoutErr(timeoutErr),
        .conflictCnt(conflictCnt), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Model: one outstanding transaction; busy = granted, done = memory finished (response cycle)
    bit          b_busy = 0, b_done = 0, t_if = 1, t_we = 0, t_killed = 0, t_to = 0;
    int          t_wait = 0;
    logic [31:0] b_addr = 0, b_wdata = 0, b_ifr = 0, b_dr = 0, b_conf = 0, b_stall = 0;
    logic        e_ifr, e_dr, e_rd, e_wr, e_ifs, e_ds, l_ifr = 0, l_dr = 0;

    always @(negedge clk) begin
        e_ifr = b_done && t_if && !(t_killed || ifKill);
        e_dr  = b_done && !t_if;
        e_rd  = b_busy && !b_done && !t_we;
        e_wr  = b_busy && !b_done && t_we;
        e_ifs = ifReq && !e_ifr;
        e_ds  = dReq && !e_dr;
        chk("ifReady", ifReady, e_ifr);
        chk("dReady", dReady, e_dr);
        chk("mRead", mRead, e_rd);
        chk("mWrite", mWrite, e_wr);
        chk("ifStall", ifStall, e_ifs);
        chk("dStall", dStall, e_ds);
        chk("timeoutErr", timeoutErr, b_done && t_to);
        chk("mAddr", mAddr, b_addr);
        chk("ifRdata", ifRdata, b_ifr);
        chk("dRdata", dRdata, b_dr);
        if (e_wr) chk("mWdata", mWdata, b_wdata);
`ifdef ARB_PERF_EN
        chk("conflictCnt", conflictCnt, b_conf);
        chk("stallCnt", stallCnt, b_stall);
`else
        chk("conflictCnt", conflictCnt, 32'd0);
        chk("stallCnt", stallCnt, 32'd0);
`endif
        l_ifr = e_ifr;
        l_dr  = e_dr;
        if (rst) begin
            b_busy = 0; b_done = 0; t_if = 1; t_we = 0; t_killed = 0; t_to = 0;
            b_addr = 0; b_wdata = 0; b_ifr = 0; b_dr = 0; b_conf = 0; b_stall = 0;
        end else begin
            if (!b_busy && ifReq && dReq && b_conf != 32'hFFFF_FFFF) b_conf++;
            if ((e_ifs || e_ds) && b_stall != 32'hFFFF_FFFF) b_stall++;
            if (!b_busy) begin
                if (dReq || (ifReq && !ifKill)) begin
                    b_busy = 1; t_if = !dReq; t_we = dReq && dWe;
                    b_addr = dReq ? dAddr : ifAddr;
                    if (dReq) b_wdata = dWdata;
                    t_wait = 0; t_killed = 0; t_to = 0;
                end
            end else if (!b_done) begin
                t_wait++;
                if (t_if && ifKill) t_killed = 1;
                if (mReady || t_wait == TO) begin
                    b_done = 1;
                    t_to = !mReady;
                    if (t_if) b_ifr = mReady ? mRdata : 0;
                    else b_dr = mReady ? mRdata : 0;
                end
            end else begin
                b_busy = 0; b_done = 0;
            end
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    int wr;

    initial begin
        rst = 1; ifReq = 0; ifKill = 0; dReq = 0; dWe = 0; mReady = 0;
        ifAddr = 0; dAddr = 0; dWdata = 0; mRdata = 0;
        repeat (3) nx();
        @(negedge clk);
        chk("rst_mRead", mRead, 0);
        chk("rst_mAddr", mAddr, 0);
        chk("rst_ifRdata", ifRdata, 0);
        chk("rst_dReady", dReady, 0);
        // single fetch, memory answers in the first command cycle
        nx(); rst = 0; ifReq = 1; ifAddr = 32'h40;
        @(negedge clk); chk("t1_stall", ifStall, 1); chk("t1_idle_mread", mRead, 0);
        nx(); mReady = 1; mRdata = 32'h1234_5678;
        @(negedge clk); chk("t1_mread", mRead, 1); chk("t1_maddr", mAddr, 32'h40);
        nx(); mReady = 0;
        @(negedge clk); chk("t1_ready", ifReady, 1); chk("t1_rdata", ifRdata, 32'h1234_5678);
        chk("t1_nostall", ifStall, 0);
        // fetch and load together: load first
        nx(); ifReq = 1; ifAddr = 32'h44; dReq = 1; dWe = 0; dAddr = 32'h100;
        @(negedge clk); chk("t2_dstall", dStall, 1);
        nx(); mReady = 1; mRdata = 32'hAAAA_5555;
        @(negedge clk); chk("t2_maddr_d", mAddr, 32'h100); chk("t2_mread_d", mRead, 1);
        nx(); mReady = 0;
        @(negedge clk); chk("t2_dready", dReady, 1); chk("t2_drdata", dRdata, 32'hAAAA_5555);
        chk("t2_if_wait", ifReady, 0);
        nx(); dReq = 0;
        @(negedge clk); chk("t2_idle", mRead, 0); chk("t2_ifstall", ifStall, 1);
        nx(); mReady = 1; mRdata = 32'h0BAD_F00D;
        @(negedge clk); chk("t2_maddr_if", mAddr, 32'h44);
        nx(); mReady = 0;
        @(negedge clk); chk("t2_ifready", ifReady, 1); chk("t2_ifrdata", ifRdata, 32'h0BAD_F00D);
        chk("t2_drdata_hold", dRdata, 32'hAAAA_5555);
        // store with three wait cycles
        nx(); ifReq = 0; dReq = 1; dWe = 1; dAddr = 32'h8; dWdata = 32'hDEAD_BEEF;
        wr = 0;
        for (int i = 0; i < 3; i++) begin
            nx(); mReady = (i == 2);
            @(negedge clk); wr += int'(mWrite); chk("t3_wdata", mWdata, 32'hDEAD_BEEF);
        end
        nx(); mReady = 0;
        @(negedge clk); chk("t3_dready", dReady, 1); chk("t3_no_ifready", ifReady, 0);
        chk("t3_write_cycles", wr, 3); chk("t3_mwrite_off", mWrite, 0);
        // killed fetch, then a normal one
        nx(); dReq = 0; dWe = 0; ifReq = 1; ifAddr = 32'h80;
        nx(); ifKill = 1;
        @(negedge clk); chk("t4_mread", mRead, 1);
        nx(); ifKill = 0; mReady = 1; mRdata = 32'h5555_0000;
        nx(); mReady = 0; ifAddr = 32'h90;
        @(negedge clk); chk("t4_killed", ifReady, 0); chk("t4_stall", ifStall, 1);
        nx();
        nx(); mReady = 1; mRdata = 32'h9090_9090;
        @(negedge clk); chk("t4_maddr", mAddr, 32'h90);
        nx(); mReady = 0;
        @(negedge clk); chk("t4_ready", ifReady, 1); chk("t4_rdata", ifRdata, 32'h9090_9090);
        // load that times out
        nx(); ifReq = 0; dReq = 1; dWe = 0; dAddr = 32'h20;
        for (int i = 0; i < TO; i++) begin
            nx();
            @(negedge clk); chk("t5_mread", mRead, 1); chk("t5_no_to", timeoutErr, 0);
        end
        nx();
        @(negedge clk); chk("t5_to", timeoutErr, 1); chk("t5_dready", dReady, 1);
        chk("t5_drdata", dRdata, 0); chk("t5_mread_off", mRead, 0);
        // reset in the middle of a fetch
        nx(); dReq = 0; ifReq = 1; ifAddr = 32'hC0;
        @(negedge clk); chk("t5_to_off", timeoutErr, 0);
        nx(); rst = 1;
        @(negedge clk); chk("t6_mread", mRead, 1);
        nx(); rst = 0; ifReq = 0;
        @(negedge clk); chk("t6_mread_off", mRead, 0); chk("t6_noready", ifReady, 0);
        chk("t6_conf", conflictCnt, 0); chk("t6_stallcnt", stallCnt, 0);
        nx();
        @(negedge clk); chk("t6_idle", ifReady, 0);
        // random traffic; requesters hold until their ready pulse (or a flush)
        for (int c = 0; c < 4000; c++) begin
            nx();
            rst = ($urandom_range(0, 199) == 0);
            if (!ifReq || l_ifr || ifKill) begin
                ifReq  = ($urandom_range(0, 9) < 6);
                ifAddr = $urandom & 32'h0000_FFFC;
            end
            ifKill = ($urandom_range(0, 11) == 0);
            if (!dReq || l_dr) begin
                dReq   = ($urandom_range(0, 9) < 4);
                dWe    = $urandom_range(0, 1) == 1;
                dAddr  = $urandom & 32'h0000_FFFC;
                dWdata = $urandom;
            end
            mReady = ($urandom_range(0, 9) < 4);
            mRdata = $urandom;
        end
        nx();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
